sum_bcd_display: RTL

//  Downstream stage of the 5-bit ripple adder. Captures the 6-bit result {cout,s[4:0]} (0..62) on a start strobe.

---
 rtl/siecomp_disp_pkg.sv | 27 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/sum_bcd_display.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/siecomp_disp_pkg.sv
// Shared definitions for the sum BCD display: FSM encoding, conversion width
// and active-low 7-segment codes in {g,f,e,d,c,b,a} order.
package siecomp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_BITS = 6;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder; codes above 9 blank
// the digit.
module bcd_to_7seg
  import siecomp_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Digit lookup with blank for non-decimal codes
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Captures {cout,s}, converts it to two BCD digits by double-dabble and drives a
// 2-digit multiplexed 7-segment display. Option: BLANK_LEADING_ZERO_EN.
module sum_bcd_display
  import siecomp_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       s,
  input  logic             cout,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [1:0]       digit_sel,
  output logic [6:0]       seg
);

  state_e           state_q;
  logic [5:0]       val_q;
  logic [1:0]       tens_q;
  logic [3:0]       ones_q;
  logic [2:0]       bit_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       bcd_tens_q;
  logic [3:0]       bcd_ones_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       digit_sel_q;
  logic [6:0]       seg_q;

  logic [3:0]       ones_adj_s;
  logic [2:0]       tens_d;
  logic [3:0]       ones_d;
  logic [5:0]       val_d;
  logic             last_shift_s;
  logic [3:0]       bcd_tens_d;
  logic [3:0]       bcd_ones_d;

  // One double-dabble step. Scratch tens never exceeds 3 before the final
  // shift, so only two bits are kept; the third appears on the last shift.
  always_comb begin
    if (ones_q >= 4'd5) begin
      ones_adj_s = ones_q + 4'd3;
    end else begin
      ones_adj_s = ones_q;
    end
    {tens_d, ones_d, val_d} = {tens_q, ones_adj_s, val_q, 1'b0};
    last_shift_s = (state_q == CONV) && (bit_cnt_q == 3'(NUM_BITS - 1));
    if (last_shift_s) begin
      bcd_tens_d = {1'b0, tens_d};
      bcd_ones_d = ones_d;
    end else begin
      bcd_tens_d = bcd_tens_q;
      bcd_ones_d = bcd_ones_q;
    end
  end

  // Capture/convert FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      val_q      <= 6'd0;
      tens_q     <= 2'd0;
      ones_q     <= 4'd0;
      bit_cnt_q  <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_tens_q <= 4'd0;
      bcd_ones_q <= 4'd0;
    end else begin
      bcd_tens_q <= bcd_tens_d;
      bcd_ones_q <= bcd_ones_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            val_q     <= {cout, s};
            tens_q    <= 2'd0;
            ones_q    <= 4'd0;
            bit_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end else begin
            busy_q    <= 1'b0;
          end
        end
        CONV: begin
          tens_q    <= tens_d[1:0];
          ones_q    <= ones_d;
          val_q     <= val_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (last_shift_s) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic             cnt_wrap_s;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       digit_sel_d;
  logic [3:0]       digit_s;
  logic [6:0]       seg_s;

  // Refresh timing and digit mux; uses next-state values so seg always
  // matches the registered digit_sel and bcd outputs
  always_comb begin
    cnt_wrap_s = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    if (cnt_wrap_s) begin
      cnt_d       = {CNT_W{1'b0}};
      digit_sel_d = ~digit_sel_q;
    end else begin
      cnt_d       = cnt_q + CNT_W'(1);
      digit_sel_d = digit_sel_q;
    end
    if (digit_sel_d == 2'b01) begin
`ifdef BLANK_LEADING_ZERO_EN
      if (bcd_tens_d == 4'd0) begin
        digit_s = BCD_BLANK;
      end else begin
        digit_s = bcd_tens_d;
      end
`else
      digit_s = bcd_tens_d;
`endif
    end else begin
      digit_s = bcd_ones_d;
    end
  end

  bcd_to_7seg u_dec (
    .bcd_i (digit_s),
    .seg_o (seg_s)
  );

  // Display refresh registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= {CNT_W{1'b0}};
      digit_sel_q <= 2'b10;
      seg_q       <= SEG_0;
    end else begin
      cnt_q       <= cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_s;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_tens  = bcd_tens_q;
  assign bcd_ones  = bcd_ones_q;
  assign digit_sel = digit_sel_q;
  assign seg       = seg_q;

endmodule
